// File: rtl/scfifolut_if.sv
// scfifolut_if: bundles the FIFO's control, data and status signals.
//   master modport: the FIFO user (drives clr/wen/wdata/ren, observes status).
//   slave modport : the FIFO itself (observes requests, drives data/status).
// Signals: clr, wen, wdata, ren (requests); wfull, almost_full, rdata, rempty,
//          almost_empty, level, overflow, underflow (data/status).
interface scfifolut_if #(
   parameter int unsigned LOG2_FIFO_DEPTH = 3,
   parameter int unsigned FIFO_WIDTH      = 8
);
   logic                       clr;
   logic                       wen;
   logic [FIFO_WIDTH-1:0]      wdata;
   logic                       wfull;
   logic                       almost_full;
   logic                       ren;
   logic [FIFO_WIDTH-1:0]      rdata;
   logic                       rempty;
   logic                       almost_empty;
   logic [LOG2_FIFO_DEPTH:0]   level;
   logic                       overflow;
   logic                       underflow;

   modport master (
      output clr, wen, wdata, ren,
      input  wfull, almost_full, rdata, rempty, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  clr, wen, wdata, ren,
      output wfull, almost_full, rdata, rempty, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/scfifolut.sv
// scfifolut: single-clock FIFO on distributed (LUT) memory.
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : scfifolut_if.slave (clr/wen/wdata/ren in; rdata and status out)
// Status: wfull, almost_full (level >= AFULL_THRESH), rempty,
//         almost_empty (level <= AEMPTY_THRESH), level, sticky overflow/underflow.
// Optional build macro SCFIFOLUT_FWFT_EN selects first-word-fall-through reads
// through an output prefetch register; without it rdata is registered with a
// one-cycle read latency.
module scfifolut #(
   parameter int unsigned LOG2_FIFO_DEPTH = 3,
   parameter int unsigned FIFO_WIDTH      = 8,
   parameter int unsigned AFULL_THRESH    = 6,
   parameter int unsigned AEMPTY_THRESH   = 1
) (
   input logic        clk,
   input logic        arst_n,
   scfifolut_if.slave bus
);
   localparam int unsigned DEPTH = 1 << LOG2_FIFO_DEPTH;

   typedef logic [LOG2_FIFO_DEPTH:0]   lvl_t;
   typedef logic [LOG2_FIFO_DEPTH-1:0] ptr_t;

   localparam lvl_t LvlFull   = lvl_t'(DEPTH);
   localparam lvl_t LvlAfull  = lvl_t'(AFULL_THRESH);
   localparam lvl_t LvlAempty = lvl_t'(AEMPTY_THRESH);

   logic [FIFO_WIDTH-1:0] mem_q [DEPTH];
   ptr_t                  wptr_q, rptr_q;
   lvl_t                  level_q, level_d;
   logic [FIFO_WIDTH-1:0] rdata_q;
   logic                  overflow_q, underflow_q;
   logic                  full, empty, push, pop;

`ifdef SCFIFOLUT_FWFT_EN
   logic pf_valid_q, pf_valid_d;
   lvl_t mem_cnt;
   logic pf_load;

   // level includes the prefetch word; memory holds the remainder.
   assign mem_cnt = level_q - lvl_t'(pf_valid_q);
   assign empty   = ~pf_valid_q;
   // Refill the head register whenever it is vacant or being consumed.
   assign pf_load = (mem_cnt != '0) && (!pf_valid_q || pop);

   always_comb begin
      pf_valid_d = pf_valid_q;
      if (pf_load) begin
         pf_valid_d = 1'b1;
      end else if (pop) begin
         pf_valid_d = 1'b0;
      end
   end
`else
   assign empty = (level_q == '0);
`endif

   assign full = (level_q == LvlFull);
   // clr swallows same-cycle requests, so they neither move state nor set errors.
   assign push = bus.wen & ~full & ~bus.clr;
   assign pop  = bus.ren & ~empty & ~bus.clr;

   always_comb begin
      level_d = level_q + lvl_t'(push) - lvl_t'(pop);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef SCFIFOLUT_FWFT_EN
         pf_valid_q  <= 1'b0;
`endif
      end else if (bus.clr) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef SCFIFOLUT_FWFT_EN
         pf_valid_q  <= 1'b0;
`endif
      end else begin
         level_q <= level_d;
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (bus.wen && full) begin
            overflow_q <= 1'b1;
         end
         if (bus.ren && empty) begin
            underflow_q <= 1'b1;
         end
`ifdef SCFIFOLUT_FWFT_EN
         pf_valid_q <= pf_valid_d;
         if (pf_load) begin
            rdata_q <= mem_q[rptr_q];
            rptr_q  <= rptr_q + 1'b1;
         end
`else
         if (pop) begin
            rdata_q <= mem_q[rptr_q];
            rptr_q  <= rptr_q + 1'b1;
         end
`endif
      end
   end

   // Storage is not reset so it maps onto LUT RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= bus.wdata;
      end
   end

   assign bus.wfull        = full;
   assign bus.almost_full  = (level_q >= LvlAfull);
   assign bus.rempty       = empty;
   assign bus.almost_empty = (level_q <= LvlAempty);
   assign bus.level        = level_q;
   assign bus.rdata        = rdata_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_scfifolut.sv
// tb_scfifolut: randomized and directed checks of scfifolut (standard read mode)
// against a queue-based reference model.
module tb_scfifolut;
   localparam int unsigned L     = 3;
   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AFT   = 6;
   localparam int unsigned AET   = 1;

   logic clk;
   logic arst_n;
   int   checks;
   int   failures;

   scfifolut_if #(.LOG2_FIFO_DEPTH(L), .FIFO_WIDTH(W)) bus ();

   scfifolut #(
      .LOG2_FIFO_DEPTH(L),
      .FIFO_WIDTH     (W),
      .AFULL_THRESH   (AFT),
      .AEMPTY_THRESH  (AET)
   ) dut (
      .clk   (clk),
      .arst_n(arst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_rdata;
   logic         m_ovf;
   logic         m_unf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = mq.size();
      check({tag, ".level"}, 32'(bus.level), n);
      check({tag, ".wfull"}, 32'(bus.wfull), 32'(n == DEPTH));
      check({tag, ".rempty"}, 32'(bus.rempty), 32'(n == 0));
      check({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= AFT));
      check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AET));
      check({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
      check({tag, ".unf"}, 32'(bus.underflow), 32'(m_unf));
      check({tag, ".rdata"}, 32'(bus.rdata), 32'(m_rdata));
   endtask

   // One clock: apply requests, advance the model by the FIFO rules, check after the edge.
   task automatic step(input logic wen, input logic [W-1:0] wdata, input logic ren,
                       input logic clr, input string tag);
      bit was_full, was_empty;
      bus.wen   = wen;
      bus.wdata = wdata;
      bus.ren   = ren;
      bus.clr   = clr;
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (ren && !was_empty) m_rdata = mq.pop_front();
         if (ren && was_empty) m_unf = 1'b1;
         if (wen && !was_full) mq.push_back(wdata);
         if (wen && was_full) m_ovf = 1'b1;
      end
      #1;
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      bus.clr = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [W-1:0] d;
      checks   = 0;
      failures = 0;
      bus.clr  = 1'b0;
      bus.wen  = 1'b0;
      bus.ren  = 1'b0;
      bus.wdata = '0;
      arst_n   = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      arst_n = 1'b1;
      #2;
      @(posedge clk);
      #1;

      // Fill 1..8, then one rejected write.
      for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0, "fill");
      step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
      step(1'b1, 8'hAB, 1'b1, 1'b0, "ovf_rdwr");
      // Drain the remaining seven, then over-read.
      for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
      step(1'b0, '0, 1'b1, 1'b0, "underflow");
      step(1'b0, '0, 1'b0, 1'b0, "idle");

      // Clear flags, build level 4, then stream simultaneous read/write.
      step(1'b0, '0, 1'b0, 1'b1, "clr0");
      for (int i = 0; i < 4; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0, "pre4");
      for (int i = 0; i < 20; i++) step(1'b1, W'(8'h14 + i), 1'b1, 1'b0, "simul");

      // Level 5 with overflow set, then clr with a write.
      for (int i = 0; i < 4; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0, "top");
      step(1'b1, 8'hEE, 1'b0, 1'b0, "ovf2");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "to5");
      step(1'b1, 8'h77, 1'b1, 1'b1, "clr_wen");
      step(1'b1, 8'h55, 1'b0, 1'b0, "post_clr_w");
      step(1'b0, '0, 1'b1, 1'b0, "post_clr_r");

      // Async reset between edges while streaming.
      for (int i = 0; i < 3; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0, "stream");
      step(1'b1, 8'h63, 1'b1, 1'b0, "stream_rw");
      #2;
      arst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 8'h9C, 1'b0, 1'b0, "rt_w");
      step(1'b0, '0, 1'b1, 1'b0, "rt_r");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         d = W'($urandom);
         step(1'($urandom_range(0, 99) < 55), d, 1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 99) < 2), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
